wb_host_master: RTL and testbench

WB_HOST_MASTER -- requirements
Module: wb_host_master

---
 rtl/wb_host_master_if.sv | 38 +++
 rtl/wb_host_master.sv | 102 ++++++++++
 tb/tb_wb_host_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_host_master_if.sv
// Command/response and Wishbone classic bus bundle for wb_host_master.
// master = the host bridge, slave = the environment driving it.
interface wb_host_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output rsp_ready_i, wbm_dat_i, wbm_ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/wb_host_master.sv
// Single-outstanding command to Wishbone classic master bridge
// with ack timeout and registered response.
module wb_host_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    wb_host_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;

    logic        w_ready;
    logic        w_tmo;

    // Gated by reset so ready is low while held in reset, high right after.
    assign w_ready = (r_state == IDLE) & wb_rst_ni;
    assign w_tmo   = (r_cnt == LP_LAST);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        r_we    <= bus.cmd_we_i;
                        r_adr   <= bus.cmd_adr_i;
                        r_dat   <= bus.cmd_we_i ? bus.cmd_dat_i : 32'h0;
                        r_sel   <= bus.cmd_sel_i;
                        r_cyc   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= BUS;
                    end
                end
                BUS: begin
                    // An ack on the final allowed cycle beats the timeout.
                    if (bus.wbm_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= r_we ? 32'h0 : bus.wbm_dat_i;
                        r_rsp_err   <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_tmo) begin
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_dat   <= 32'h0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o = w_ready;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_dat_o   = r_rsp_dat;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.wbm_cyc_o   = r_cyc;
    assign bus.wbm_stb_o   = r_cyc;
    assign bus.wbm_we_o    = r_we;
    assign bus.wbm_adr_o   = r_adr;
    assign bus.wbm_dat_o   = r_dat;
    assign bus.wbm_sel_o   = r_sel;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master.
// u_dut uses TIMEOUT_CYCLES=4, u_dut3 uses TIMEOUT_CYCLES=3.
module tb_wb_host_master;

    logic clk;
    logic rst_n;
    logic r_ack;
    logic r_auto;
    int   n_run;
    int   n_fail;

    wb_host_master_if bi ();
    wb_host_master_if bi3 ();

    assign bi.wbm_ack_i = r_ack | (r_auto & bi.wbm_cyc_o);

    wb_host_master #(.TIMEOUT_CYCLES(4)) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bi)
    );

    wb_host_master #(.TIMEOUT_CYCLES(3)) u_dut3 (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bi3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic we, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel);
        bi.cmd_we_i    = we;
        bi.cmd_adr_i   = adr;
        bi.cmd_dat_i   = dat;
        bi.cmd_sel_i   = sel;
        bi.cmd_valid_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_run++;
        if ({bi.wbm_cyc_o, bi.wbm_stb_o, bi.rsp_valid_o, bi.cmd_ready_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 0000",
                     {bi.wbm_cyc_o, bi.wbm_stb_o, bi.rsp_valid_o, bi.cmd_ready_o});
        end
        n_run++;
        if ({bi.wbm_adr_o, bi.wbm_dat_o, bi.rsp_dat_o} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0",
                     {bi.wbm_adr_o, bi.wbm_dat_o, bi.rsp_dat_o});
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_run++;
        if (bi.cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bi.cmd_ready_o);
        end
    endtask

    task automatic test_write();
        bi.rsp_ready_i = 1'b1;
        drive_cmd(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF);
        tick();
        bi.cmd_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if ({bi.wbm_cyc_o, bi.wbm_stb_o, bi.wbm_we_o, bi.wbm_adr_o,
                 bi.wbm_dat_o, bi.wbm_sel_o, bi.cmd_ready_o} !==
                {3'b111, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, 1'b0}) begin
                n_fail++;
                $display("FAIL write_bus[%0d]: got cyc=%b adr=%h dat=%h want 1 30000004 a5a55a5a",
                         i, bi.wbm_cyc_o, bi.wbm_adr_o, bi.wbm_dat_o);
            end
            if (i == 2) r_ack = 1'b1;
            tick();
        end
        r_ack = 1'b0;
        n_run++;
        if ({bi.wbm_cyc_o, bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o} !==
            {3'b010, 32'h0}) begin
            n_fail++;
            $display("FAIL write_rsp: got cyc=%b v=%b e=%b d=%h want 0 1 0 0",
                     bi.wbm_cyc_o, bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o);
        end
        tick();
        n_run++;
        if ({bi.rsp_valid_o, bi.cmd_ready_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL write_idle: got %b want 01", {bi.rsp_valid_o, bi.cmd_ready_o});
        end
    endtask

    task automatic test_read();
        r_auto = 1'b1;
        bi.wbm_dat_i = 32'h1234_5678;
        drive_cmd(1'b0, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF);
        tick();
        bi.cmd_valid_i = 1'b0;
        n_run++;
        if ({bi.wbm_cyc_o, bi.wbm_we_o, bi.wbm_dat_o} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL read_bus: got cyc=%b we=%b dat=%h want 1 0 0",
                     bi.wbm_cyc_o, bi.wbm_we_o, bi.wbm_dat_o);
        end
        tick();
        bi.wbm_dat_i = 32'h0;
        n_run++;
        if ({bi.wbm_cyc_o, bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o, bi.wbm_dat_o} !==
            {3'b010, 32'h1234_5678, 32'h0}) begin
            n_fail++;
            $display("FAIL read_rsp: got v=%b e=%b d=%h want 1 0 12345678",
                     bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o);
        end
        tick();
        r_auto = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bi.wbm_dat_i = 32'hDEAD_BEEF;
        drive_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h3);
        tick();
        bi.cmd_valid_i = 1'b0;
        n = 0;
        while (bi.wbm_cyc_o && n < 20) begin
            n++;
            tick();
        end
        n_run++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d cycles want 4", n);
        end
        n_run++;
        if ({bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL timeout_rsp: got v=%b e=%b d=%h want 1 1 0",
                     bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o);
        end
        tick();
    endtask

    task automatic test_ack_ignored();
        r_ack = 1'b1;
        bi.wbm_dat_i = 32'h5555_AAAA;
        tick();
        tick();
        r_ack = 1'b0;
        n_run++;
        if ({bi.wbm_cyc_o, bi.rsp_valid_o, bi.cmd_ready_o, bi.rsp_dat_o} !==
            {3'b001, 32'h0}) begin
            n_fail++;
            $display("FAIL ack_idle: got cyc=%b v=%b rdy=%b d=%h want 0 0 1 0",
                     bi.wbm_cyc_o, bi.rsp_valid_o, bi.cmd_ready_o, bi.rsp_dat_o);
        end
    endtask

    task automatic test_backpressure();
        bi.rsp_ready_i = 1'b0;
        r_auto = 1'b1;
        bi.wbm_dat_i = 32'h0BAD_F00D;
        drive_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        tick();
        drive_cmd(1'b1, 32'h0000_0200, 32'h0000_0077, 4'h3);
        tick();
        bi.wbm_dat_i = 32'h0;
        for (int i = 0; i < 10; i++) begin
            n_run++;
            if ({bi.cmd_ready_o, bi.wbm_cyc_o, bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o} !==
                {4'b0010, 32'h0BAD_F00D}) begin
                n_fail++;
                $display("FAIL hold[%0d]: got rdy=%b v=%b e=%b d=%h want 0 1 0 0badf00d",
                         i, bi.cmd_ready_o, bi.rsp_valid_o, bi.rsp_err_o, bi.rsp_dat_o);
            end
            tick();
        end
        bi.rsp_ready_i = 1'b1;
        n_run++;
        if ({bi.cmd_ready_o, bi.rsp_valid_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_hs: got rdy=%b v=%b want 0 1", bi.cmd_ready_o, bi.rsp_valid_o);
        end
        tick();
        n_run++;
        if ({bi.cmd_ready_o, bi.rsp_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_idle: got rdy=%b v=%b want 1 0", bi.cmd_ready_o, bi.rsp_valid_o);
        end
        tick();
        bi.cmd_valid_i = 1'b0;
        n_run++;
        if ({bi.wbm_cyc_o, bi.wbm_we_o, bi.wbm_adr_o, bi.wbm_sel_o} !==
            {2'b11, 32'h0000_0200, 4'h3}) begin
            n_fail++;
            $display("FAIL hold_next: got cyc=%b we=%b adr=%h want 1 1 00000200",
                     bi.wbm_cyc_o, bi.wbm_we_o, bi.wbm_adr_o);
        end
        tick();
        n_run++;
        if ({bi.rsp_valid_o, bi.rsp_dat_o} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL hold_wrsp: got v=%b d=%h want 1 0", bi.rsp_valid_o, bi.rsp_dat_o);
        end
        tick();
        r_auto = 1'b0;
    endtask

    task automatic test_back_to_back();
        int hs;
        int cyc_n;
        hs = 0;
        cyc_n = 0;
        r_auto = 1'b1;
        drive_cmd(1'b1, 32'h0000_0010, 32'h1111_2222, 4'hF);
        for (int i = 0; i < 9; i++) begin
            if (bi.cmd_valid_i && bi.cmd_ready_o) hs++;
            if (bi.wbm_cyc_o) cyc_n++;
            tick();
        end
        bi.cmd_valid_i = 1'b0;
        tick();
        r_auto = 1'b0;
        n_run++;
        if (hs !== 3 || cyc_n !== 3) begin
            n_fail++;
            $display("FAIL b2b: got hs=%0d cyc=%0d want 3 3", hs, cyc_n);
        end
    endtask

    task automatic test_reset_mid_bus();
        drive_cmd(1'b1, 32'h0000_0040, 32'h0000_00AA, 4'h1);
        tick();
        bi.cmd_valid_i = 1'b0;
        n_run++;
        if (bi.wbm_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got cyc=%b want 1", bi.wbm_cyc_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({bi.wbm_cyc_o, bi.wbm_stb_o, bi.cmd_ready_o, bi.rsp_valid_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_async: got %b want 0000",
                     {bi.wbm_cyc_o, bi.wbm_stb_o, bi.cmd_ready_o, bi.rsp_valid_o});
        end
        #1;
        rst_n = 1'b1;
        tick();
        r_ack = 1'b1;
        tick();
        r_ack = 1'b0;
        n_run++;
        if ({bi.wbm_cyc_o, bi.rsp_valid_o, bi.cmd_ready_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_after: got cyc=%b v=%b rdy=%b want 0 0 1",
                     bi.wbm_cyc_o, bi.rsp_valid_o, bi.cmd_ready_o);
        end
        drive_cmd(1'b0, 32'h0000_0044, 32'h0, 4'hF);
        tick();
        bi.cmd_valid_i = 1'b0;
        n_run++;
        if ({bi.wbm_cyc_o, bi.wbm_adr_o} !== {1'b1, 32'h0000_0044}) begin
            n_fail++;
            $display("FAIL rst_first: got cyc=%b adr=%h want 1 00000044",
                     bi.wbm_cyc_o, bi.wbm_adr_o);
        end
        r_ack = 1'b1;
        tick();
        r_ack = 1'b0;
        tick();
    endtask

    task automatic test_ack_at_timeout();
        int n;
        bi3.rsp_ready_i = 1'b1;
        bi3.wbm_dat_i = 32'hCAFE_F00D;
        bi3.cmd_we_i = 1'b0;
        bi3.cmd_adr_i = 32'h0000_0080;
        bi3.cmd_valid_i = 1'b1;
        tick();
        bi3.cmd_valid_i = 1'b0;
        tick();
        tick();
        bi3.wbm_ack_i = 1'b1;
        n_run++;
        if (bi3.wbm_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL coin_cyc: got cyc=%b want 1", bi3.wbm_cyc_o);
        end
        tick();
        bi3.wbm_ack_i = 1'b0;
        n_run++;
        if ({bi3.rsp_valid_o, bi3.rsp_err_o, bi3.rsp_dat_o} !== {2'b10, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL coin_rsp: got v=%b e=%b d=%h want 1 0 cafef00d",
                     bi3.rsp_valid_o, bi3.rsp_err_o, bi3.rsp_dat_o);
        end
        tick();
        bi3.cmd_valid_i = 1'b1;
        tick();
        bi3.cmd_valid_i = 1'b0;
        n = 0;
        while (bi3.wbm_cyc_o && n < 20) begin
            n++;
            tick();
        end
        n_run++;
        if (n !== 3 || bi3.rsp_err_o !== 1'b1 || bi3.rsp_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL t3_timeout: got n=%0d e=%b d=%h want 3 1 0",
                     n, bi3.rsp_err_o, bi3.rsp_dat_o);
        end
        tick();
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        r_ack = 1'b0;
        r_auto = 1'b0;
        rst_n = 1'b0;
        bi.cmd_valid_i = 1'b0;
        bi.cmd_we_i = 1'b0;
        bi.cmd_adr_i = '0;
        bi.cmd_dat_i = '0;
        bi.cmd_sel_i = '0;
        bi.rsp_ready_i = 1'b1;
        bi.wbm_dat_i = '0;
        bi3.cmd_valid_i = 1'b0;
        bi3.cmd_we_i = 1'b0;
        bi3.cmd_adr_i = '0;
        bi3.cmd_dat_i = '0;
        bi3.cmd_sel_i = 4'hF;
        bi3.rsp_ready_i = 1'b1;
        bi3.wbm_dat_i = '0;
        bi3.wbm_ack_i = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_ignored();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        test_ack_at_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
